// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, types and constants for the RV64 integer datapath
package riscv_pkg;
    localparam int XLEN    = 64;
    localparam int NREG_AW = 5;
    typedef logic [XLEN-1:0]    xlen_t;
    typedef logic [NREG_AW-1:0] reg_addr_t;
    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: combinational read mux with x0 zero-force and optional write-first bypass
module regfile_read_port
    import riscv_pkg::*;
#(
    parameter int XLEN        = riscv_pkg::XLEN,
    parameter int NREGS       = 32,
    parameter int AW          = riscv_pkg::NREG_AW,
    parameter int WRITE_FIRST = 0
) (
    input  logic                        i_rst,
    input  logic [NREGS-1:0][XLEN-1:0]  i_regs,
    input  logic [AW-1:0]               i_addr,
    input  logic                        i_we,
    input  logic [AW-1:0]               i_waddr,
    input  logic [XLEN-1:0]             i_wdata,
    output logic [XLEN-1:0]             o_data
);
    logic w_bypass;
    // Bypass is suppressed in reset so both ports read zero while rst is high
    assign w_bypass = (WRITE_FIRST != 0) && i_we && !i_rst && (i_waddr == i_addr);
    // x0 wins over the bypass so a write aimed at x0 can never leak out
    assign o_data = (i_addr == REG_ZERO) ? '0 : w_bypass ? i_wdata : i_regs[i_addr];
endmodule

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32 x XLEN integer register file, two combinational reads, one clocked write
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN        = riscv_pkg::XLEN,
    parameter int NREGS       = 32,
    parameter int AW          = riscv_pkg::NREG_AW,
    parameter int WRITE_FIRST = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regWrite,
    input  logic [AW-1:0]   readRegister1,
    input  logic [AW-1:0]   readRegister2,
    input  logic [AW-1:0]   writeRegister,
    input  logic [XLEN-1:0] writeData,
    output logic [XLEN-1:0] readData1,
    output logic [XLEN-1:0] readData2
);
    logic [NREGS-1:0][XLEN-1:0] r_regs;
    // Storage: async clear, single-cycle write, writes to x0 dropped so entry 0 stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_regs <= '0;
        else if (regWrite && writeRegister != REG_ZERO)
            r_regs[writeRegister] <= writeData;
    end
    regfile_read_port #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .WRITE_FIRST(WRITE_FIRST)
    ) u_rp1 (
        .i_rst(rst), .i_regs(r_regs), .i_addr(readRegister1), .i_we(regWrite),
        .i_waddr(writeRegister), .i_wdata(writeData), .o_data(readData1)
    );
    regfile_read_port #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .WRITE_FIRST(WRITE_FIRST)
    ) u_rp2 (
        .i_rst(rst), .i_regs(r_regs), .i_addr(readRegister2), .i_we(regWrite),
        .i_waddr(writeRegister), .i_wdata(writeData), .o_data(readData2)
    );
endmodule

// File: tb/tb_riscv_regfile.sv
// tb_riscv_regfile: directed scoreboard bench driving a write-old and a write-first instance in parallel
module tb_riscv_regfile;
    logic        clk = 0;
    logic        clk_run = 1;
    logic        rst = 1;
    logic        regWrite = 0;
    logic [4:0]  readRegister1 = 0;
    logic [4:0]  readRegister2 = 0;
    logic [4:0]  writeRegister = 0;
    logic [63:0] writeData = 0;
    logic [63:0] rd1_a, rd2_a, rd1_b, rd2_b;

    logic [63:0] model [32];
    logic [63:0] exp_q [$];
    int total = 0;
    int bad = 0;

    riscv_regfile #(.WRITE_FIRST(0)) dut_wf0 (
        .clk(clk), .rst(rst), .regWrite(regWrite),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .writeRegister(writeRegister), .writeData(writeData),
        .readData1(rd1_a), .readData2(rd2_a)
    );
    riscv_regfile #(.WRITE_FIRST(1)) dut_wf1 (
        .clk(clk), .rst(rst), .regWrite(regWrite),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .writeRegister(writeRegister), .writeData(writeData),
        .readData1(rd1_b), .readData2(rd2_b)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic cmp(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        e = exp_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic cmp4(input string tag);
        cmp({tag, "/wf0/p1"}, rd1_a);
        cmp({tag, "/wf0/p2"}, rd2_a);
        cmp({tag, "/wf1/p1"}, rd1_b);
        cmp({tag, "/wf1/p2"}, rd2_b);
    endtask

    task automatic rd(input int a1, input int a2, input string tag);
        readRegister1 = 5'(a1);
        readRegister2 = 5'(a2);
        exp_q.push_back(model[a1]);
        exp_q.push_back(model[a2]);
        exp_q.push_back(model[a1]);
        exp_q.push_back(model[a2]);
        #1;
        cmp4($sformatf("%s[%0d,%0d]", tag, a1, a2));
    endtask

    task automatic wr(input int a, input logic [63:0] d);
        @(negedge clk);
        regWrite = 1;
        writeRegister = 5'(a);
        writeData = d;
        @(posedge clk);
        #1;
        regWrite = 0;
        if (a != 0) model[a] = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // preload so the async clear has something to wipe
        for (int i = 1; i < 5; i++) wr(i, 64'h100 + 64'(i));
        rd(1, 4, "preload");

        // async reset with the clock stopped low
        @(negedge clk);
        clk_run = 0;
        #2;
        rst = 1;
        for (int i = 0; i < 32; i++) model[i] = 0;
        #1;
        for (int i = 0; i < 32; i++) rd(i, 31 - i, "async_rst");
        regWrite = 1;
        writeRegister = 5'd2;
        writeData = 64'h55;
        rd(2, 2, "rst_write_ignored");
        regWrite = 0;
        #1;
        rst = 0;
        clk_run = 1;

        // sequential writes, then paired reads
        for (int i = 0; i < 16; i++) wr(i, 64'(i + 1));
        for (int i = 0; i < 16; i++) rd(i, i + 1, "seq");

        // write disable
        @(negedge clk);
        regWrite = 0;
        writeRegister = 5'd5;
        writeData = 64'hDEADBEEF_CAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        rd(5, 5, "wr_disable");

        // x0 protection and top register
        wr(0, '1);
        wr(31, '1);
        rd(0, 0, "x0");
        rd(31, 31, "x31");

        // read during write, x7 currently 8
        @(negedge clk);
        readRegister1 = 5'd7;
        readRegister2 = 5'd0;
        regWrite = 1;
        writeRegister = 5'd7;
        writeData = 64'h12345678;
        #1;
        exp_q.push_back(64'd8);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'h12345678);
        exp_q.push_back(64'd0);
        cmp4("rdw_before");
        @(posedge clk);
        #1;
        regWrite = 0;
        model[7] = 64'h12345678;
        rd(7, 0, "rdw_after");

        // write-first bypass must not override x0
        @(negedge clk);
        regWrite = 1;
        writeRegister = 5'd0;
        writeData = 64'hBAD;
        rd(0, 0, "x0_bypass");
        @(posedge clk);
        #1;
        regWrite = 0;
        rd(0, 0, "x0_after");

        // reset mid-operation
        wr(3, 64'h77);
        @(negedge clk);
        #1;
        rst = 1;
        for (int i = 0; i < 32; i++) model[i] = 0;
        #1;
        rd(3, 31, "midrst");
        rd(7, 15, "midrst");
        #1;
        rst = 0;
        wr(3, 64'hA5);
        rd(3, 4, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_regfile.md
Name: riscv_regfile

Overview:
- 64-bit RISC-V integer register file: 32 architectural registers x0..x31.
- Two combinational read ports and one clocked write port.
- Sits in the decode stage of the single-cycle RV64 core. The read ports feed the ALU operand muxes; the write port is driven from the writeback path.
- x0 is hardwired to zero.

Parameters:
- XLEN, 64, data width of each register and of the data ports.
- NREGS, 32, number of registers. Must be a power of two.
- AW, 5, address width. Equals log2(NREGS).
- WRITE_FIRST, 0, read-during-write policy. 0: a read returns the old value until the clock edge. 1: a read of the register being written returns writeData combinationally.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- regWrite  input  1  write enable, sampled on rising clk.
- readRegister1  input  AW  read port 1 address.
- readRegister2  input  AW  read port 2 address.
- writeRegister  input  AW  write address.
- writeData  input  XLEN  write data.
- readData1  output  XLEN  contents of readRegister1.
- readData2  output  XLEN  contents of readRegister2.

Behaviour:
- Reset:
  - rst=1 asynchronously clears all NREGS registers to 0, without waiting for clk.
  - While rst is high, writes are ignored and both read outputs show 0.
  - Reset deasserting mid-operation: the first write can occur on the first rising edge with rst=0.
- Write:
  - On a rising clk with rst=0 and regWrite=1, writeData is stored into register[writeRegister].
  - Single-cycle write; the new value is visible on the read ports immediately after the edge.
- x0:
  - A write with writeRegister=0 is discarded.
  - Reading address 0 always returns 0, regardless of WRITE_FIRST.
- Read:
  - Purely combinational, with zero-cycle latency from address to data.
  - The two ports are fully independent and may use the same address; both then return the same value.
- Read-during-write, same cycle and same nonzero address:
  - WRITE_FIRST=0: the output shows the old contents until the edge, then the new value.
  - WRITE_FIRST=1: the output shows writeData as soon as regWrite, writeRegister and writeData are valid.
- regWrite=0: no register changes, whatever writeRegister and writeData hold.
- Unknown (X/Z) read address: output is unspecified. No other state is disturbed.
- writeData is stored unmodified at full XLEN bits. There is no sign or zero extension inside the block.
- Address range: no wrap-around concern, since AW spans exactly NREGS entries.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and NREG_AW constants.
  - the typedef xlen_t (logic [XLEN-1:0]).
  - the typedef reg_addr_t (logic [AW-1:0]).
  - the constant REG_ZERO = 0.
- One sub-module is natural: regfile_read_port. It implements the address-to-data mux, including the x0 zero-force and the WRITE_FIRST bypass, and is instantiated twice.
- Storage and write logic live in the top module.

Test Plan:
- Reset: pulse rst high mid-cycle while clk is idle. All 32 registers read 0 on both ports immediately, without a clock edge.
- Sequential writes: regWrite=1; for i=0..15, writeRegister=i, writeData=i+1, one per cycle. Then regWrite=0 and read pairs (i, i+1). Required: x0=0, x1=2, x2=3, ..., x15=16, x16=0.
- Write disable: regWrite=0, writeRegister=5, writeData=64'hDEADBEEF_CAFEF00D for several cycles. x5 keeps its prior value (6).
- x0 protection and upper bound: write 64'hFFFF_FFFF_FFFF_FFFF to x0 and to x31. x0 reads 0; x31 reads all ones on both ports.
- Read-during-write with WRITE_FIRST=0: readRegister1=writeRegister=7, old value 8, writeData=64'h12345678. Before the edge readData1=8; after the edge readData1=64'h12345678. Repeat with WRITE_FIRST=1: readData1=64'h12345678 before the edge.
- Reset mid-operation: assert rst between writes. All registers read 0 at once; a subsequent write of 64'hA5 to x3 after rst deasserts reads back 64'hA5.
